// File: rtl/id_hazard_stall_ctrl.sv
// id_hazard_stall_ctrl
//   Decode-stage hazard controller for a 5-stage MIPS pipeline. It detects load-use
//   and branch-operand hazards against the ID instruction, freezes PC and IF/ID,
//   inserts bubbles into ID/EX, flushes IF/ID on taken branches and jumps, and
//   counts stall cycles.
//
//   Optional feature macro: STALL_COUNTER_EN
//     defined     -> saturating stall-cycle counter on stall_cnt
//     not defined -> no counter flops, stall_cnt tied to zero
//
// Ports
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt                  source register fields of the IF/ID instruction
//   id_uses_rs, id_uses_rt        ID instruction actually reads rs / rt
//   id_is_branch, id_branch_taken beq/bne in ID and its compare result
//   id_is_jump                    j/jal/jr in ID
//   ex_regwrite, ex_memread       ID/EX writes a register / is a load
//   ex_dst                        ID/EX destination register
//   mem_memread, mem_dst          EX/MEM is a load / its destination register
//   pc_write, if_id_write         load enables for PC and IF/ID
//   id_ex_bubble                  zero ID/EX control fields this cycle
//   if_id_flush                   clear IF/ID to nop at the next edge
//   stall_cnt                     stall cycles since reset (saturating)
module id_hazard_stall_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter bit          BRANCH_IN_ID = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             id_branch_taken,
    input  logic             id_is_jump,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [4:0]       ex_dst,
    input  logic             mem_memread,
    input  logic [4:0]       mem_dst,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun   = 2'b00,
        StHold1 = 2'b01,
        StHold2 = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic ex_hit, mem_hit, need2, need1;

    // Register 0 is hard-wired to zero, so it can never carry a dependency.
    assign ex_hit  = (ex_dst != 5'd0) &&
                     ((id_uses_rs && (ex_dst == id_rs)) || (id_uses_rt && (ex_dst == id_rt)));
    assign mem_hit = (mem_dst != 5'd0) &&
                     ((id_uses_rs && (mem_dst == id_rs)) || (id_uses_rt && (mem_dst == id_rt)));

    // A load in EX feeding a branch needs two cycles: one to reach MEM, one more for
    // the loaded value to become forwardable into the ID comparator.
    assign need2 = BRANCH_IN_ID && id_is_branch && ex_memread && ex_hit;
    assign need1 = !need2 &&
                   ((ex_memread && ex_hit) ||
                    (BRANCH_IN_ID && id_is_branch && ex_regwrite && ex_hit) ||
                    (BRANCH_IN_ID && id_is_branch && mem_memread && mem_hit));

    always_comb begin
        state_d      = StRun;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            case (state_q)
                StRun: begin
                    if (need2 || need1) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                        state_d      = need2 ? StHold1 : StRun;
                    end else begin
                        // Branch outcome is only trusted when the operands were not stalled.
                        if_id_flush = id_is_jump || (id_is_branch && id_branch_taken);
                    end
                end
                StHold1, StHold2: begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    state_d      = StRun;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef STALL_COUNTER_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_hazard_stall_ctrl.sv
// Bench for id_hazard_stall_ctrl: two instances share stimulus, one with branch
// resolution in ID and a 4-bit counter, one without branch rules and a 16-bit counter.
// Table vectors, hand sequences and random stimulus are checked against a
// cycle-level reference model.
module tb_id_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic       id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump;
    logic       ex_regwrite, ex_memread, mem_memread;

    logic        pcw1, ifw1, bub1, fl1;
    logic [3:0]  cnt1;
    logic        pcw0, ifw0, bub0, fl0;
    logic [15:0] cnt0;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: remaining forced-stall cycles and counts
    int hold1 = 0, hold0 = 0;
    int mc1 = 0, mc0 = 0;

    always #5 clk = ~clk;

    id_hazard_stall_ctrl #(.CNT_W(4), .BRANCH_IN_ID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_dst(mem_dst),
        .pc_write(pcw1), .if_id_write(ifw1), .id_ex_bubble(bub1), .if_id_flush(fl1),
        .stall_cnt(cnt1)
    );

    id_hazard_stall_ctrl #(.CNT_W(16), .BRANCH_IN_ID(1'b0)) dut0 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_dst(mem_dst),
        .pc_write(pcw0), .if_id_write(ifw0), .id_ex_bubble(bub0), .if_id_flush(fl0),
        .stall_cnt(cnt0)
    );

    typedef struct packed {
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, jmp, exw, exm;
        logic [4:0] exd;
        logic       mm;
        logic [4:0] md;
        logic       pcw1, fl1, pcw0, fl0;
    } vec_t;

    vec_t vecs[10];

    function automatic void chk(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        else n_pass++;
    endfunction

    function automatic bit hit(input logic [4:0] dst);
        return dst != 0 && ((id_uses_rs && dst == id_rs) || (id_uses_rt && dst == id_rt));
    endfunction

    // Spec rules, evaluated for a RUN-state cycle.
    function automatic void ref_comb(input bit b, output bit stall, output bit flush,
                                     output bit two);
        bit load_use, br_alu, br_mem;
        two      = b && id_is_branch && ex_memread && hit(ex_dst);
        load_use = ex_memread && hit(ex_dst);
        br_alu   = b && id_is_branch && ex_regwrite && hit(ex_dst);
        br_mem   = b && id_is_branch && mem_memread && hit(mem_dst);
        stall    = two || load_use || br_alu || br_mem;
        flush    = !stall && (id_is_jump || (id_is_branch && id_branch_taken));
    endfunction

    function automatic int exp_cnt(input int c);
`ifdef STALL_COUNTER_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic set_in(input vec_t v);
        id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        id_is_branch = v.br; id_branch_taken = v.tk; id_is_jump = v.jmp;
        ex_regwrite = v.exw; ex_memread = v.exm; ex_dst = v.exd;
        mem_memread = v.mm; mem_dst = v.md;
    endtask

    task automatic set_idle();
        vec_t v;
        v = '0;
        set_in(v);
    endtask

    // Called at posedge+1: checks the current cycle, then advances one clock.
    task automatic step(input string tag);
        bit s1, f1, t1, s0, f0, t0;
        logic [3:0] e1, e0;
        #1;
        ref_comb(1'b1, s1, f1, t1);
        ref_comb(1'b0, s0, f0, t0);
        if (hold1 > 0) begin s1 = 1; f1 = 0; t1 = 0; end
        if (hold0 > 0) begin s0 = 1; f0 = 0; t0 = 0; end
        if (reset) begin
            e1 = 4'b0010;
            e0 = 4'b0010;
        end else begin
            e1 = {!s1, !s1, s1, f1};
            e0 = {!s0, !s0, s0, f0};
        end
        chk({tag, "_out1"}, {28'd0, pcw1, ifw1, bub1, fl1}, {28'd0, e1});
        chk({tag, "_out0"}, {28'd0, pcw0, ifw0, bub0, fl0}, {28'd0, e0});
        chk({tag, "_cnt1"}, {28'd0, cnt1}, exp_cnt(mc1));
        chk({tag, "_cnt0"}, {16'd0, cnt0}, exp_cnt(mc0));
        @(posedge clk);
        if (reset) begin
            hold1 = 0; hold0 = 0; mc1 = 0; mc0 = 0;
        end else begin
            if (s1 && mc1 < 15) mc1++;
            if (s0 && mc0 < 65535) mc0++;
            hold1 = t1 ? 1 : 0;
            hold0 = t0 ? 1 : 0;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("rst");
        reset = 1'b0;
    endtask

    initial begin
        //            rs  rt  urs urt br tk jmp exw exm exd mm md  pcw1 fl1 pcw0 fl0
        vecs[0] = '{5'd2, 5'd0, 1, 0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0, 0, 0, 0, 0}; // load-use
        vecs[1] = '{5'd3, 5'd4, 1, 1, 1, 1, 0, 1, 1, 5'd3, 0, 5'd0, 0, 0, 0, 0}; // lw->beq
        vecs[2] = '{5'd5, 5'd0, 1, 1, 1, 1, 0, 1, 0, 5'd5, 0, 5'd0, 0, 0, 1, 1}; // alu->beq
        vecs[3] = '{5'd0, 5'd0, 1, 0, 0, 0, 0, 1, 1, 5'd0, 0, 5'd0, 1, 0, 1, 0}; // $0
        vecs[4] = '{5'd1, 5'd2, 1, 1, 1, 1, 0, 1, 0, 5'd7, 0, 5'd0, 1, 1, 1, 1}; // taken
        vecs[5] = '{5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 1, 1, 1, 1}; // jump
        vecs[6] = '{5'd6, 5'd0, 1, 0, 1, 1, 0, 0, 0, 5'd0, 1, 5'd6, 0, 0, 1, 1}; // mem lw->beq
        vecs[7] = '{5'd2, 5'd0, 0, 0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0, 1, 0, 1, 0}; // rs unused
        vecs[8] = '{5'd0, 5'd9, 0, 1, 0, 0, 0, 1, 1, 5'd9, 0, 5'd0, 0, 0, 0, 0}; // rt hit
        vecs[9] = '{5'd1, 5'd2, 1, 1, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 1, 0, 1, 0}; // not taken

        set_idle();
        reset = 1'b1;
        #2;
        chk("reset_async", {28'd0, pcw1, ifw1, bub1, fl1}, 32'b0010);
        @(posedge clk);
        #1;
        do_reset();

        // Table vectors, each followed by an idle cycle to drain any HOLD.
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i]);
            #1;
            chk($sformatf("vec%0d_1", i), {30'd0, pcw1, fl1}, {30'd0, vecs[i].pcw1, vecs[i].fl1});
            chk($sformatf("vec%0d_0", i), {30'd0, pcw0, fl0}, {30'd0, vecs[i].pcw0, vecs[i].fl0});
            step($sformatf("vec%0d", i));
            set_idle();
            step($sformatf("vec%0d_idle", i));
        end

        // lw $2 -> add: one stall, then lw moves to MEM and the add proceeds.
        do_reset();
        set_in(vecs[0]);
        step("lu_a");
        set_idle();
        mem_memread = 1; mem_dst = 5'd2; id_rs = 5'd2; id_uses_rs = 1;
        step("lu_b");
        chk("lu_cnt", {28'd0, cnt1}, exp_cnt(1));

        // lw $3 -> beq: two stalls, taken flag ignored while stalled.
        do_reset();
        set_in(vecs[1]);
        step("lb_a");
        step("lb_b");
        chk("lb_cnt", {28'd0, cnt1}, exp_cnt(2));

        // Async reset while in HOLD1.
        do_reset();
        set_in(vecs[1]);
        step("rh_a");
        set_idle();
        #2;
        reset = 1'b1;
        #1;
        chk("rh_out1", {28'd0, pcw1, ifw1, bub1, fl1}, 32'b0010);
        chk("rh_cnt1", {28'd0, cnt1}, 0);
        hold1 = 0; hold0 = 0; mc1 = 0; mc0 = 0;
        @(posedge clk);
        #1;
        step("rh_b");
        reset = 1'b0;
        step("rh_run");

        // Saturation: 2^4+3 stall cycles on the 4-bit counter.
        do_reset();
        set_in(vecs[0]);
        for (int i = 0; i < 19; i++) step("sat");
        chk("sat_cnt1", {28'd0, cnt1}, exp_cnt(15));
        chk("sat_cnt0", {16'd0, cnt0}, exp_cnt(19));

        // Random stimulus over a small register range to provoke hits.
        set_idle();
        for (int i = 0; i < 400; i++) begin
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom);
            id_is_branch = 1'($urandom); id_branch_taken = 1'($urandom);
            id_is_jump = ($urandom_range(0, 7) == 0);
            ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
            ex_dst = 5'($urandom_range(0, 3));
            mem_memread = 1'($urandom); mem_dst = 5'($urandom_range(0, 3));
            reset = ($urandom_range(0, 63) == 0);
            step("rand");
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/id_hazard_stall_ctrl.md
Name: id_hazard_stall_ctrl

Overview:
- Decode-stage hazard controller for the 5-stage MIPS pipeline.
- Sits beside the ID stage, where register read, immediate sign extension and branch compare happen.
- Detects load-use and branch-operand data hazards and freezes PC and IF/ID.
- Injects bubbles into ID/EX, flushes IF/ID on taken branches and jumps, and counts stall cycles.

Parameters:
- CNT_W, 16, width of stall_cnt.
- BRANCH_IN_ID, 1, 1 = branches resolve in ID and need extra operand stalls; 0 = branch stall rules disabled, only load-use applies.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_rs  input  5  rs field of instruction in IF/ID.
- id_rt  input  5  rt field of instruction in IF/ID.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_is_branch  input  1  ID instruction is beq/bne.
- id_branch_taken  input  1  ID branch compare result (valid only when no stall).
- id_is_jump  input  1  ID instruction is j/jal/jr.
- ex_regwrite  input  1  ID/EX instruction writes a register.
- ex_memread  input  1  ID/EX instruction is a load.
- ex_dst  input  5  ID/EX destination register (after RegDst mux).
- mem_memread  input  1  EX/MEM instruction is a load.
- mem_dst  input  5  EX/MEM destination register.
- pc_write  output  1  PC load enable.
- if_id_write  output  1  IF/ID load enable.
- id_ex_bubble  output  1  zero ID/EX control fields this cycle.
- if_id_flush  output  1  clear IF/ID to nop at next edge.
- stall_cnt  output  CNT_W  total stall cycles since reset.

Behaviour:
- Match definitions:
  - ex_hit = ex_dst != 0 and ((id_uses_rs and ex_dst == id_rs) or (id_uses_rt and ex_dst == id_rt)).
  - mem_hit is the same test using mem_dst.
  - Register 0 never causes a hazard.
- Stall need in RUN, evaluated combinationally:
  - need2 = BRANCH_IN_ID and id_is_branch and ex_memread and ex_hit.
  - need1 = not need2 and one of:
    - ex_memread and ex_hit (load-use).
    - BRANCH_IN_ID and id_is_branch and ex_regwrite and ex_hit.
    - BRANCH_IN_ID and id_is_branch and mem_memread and mem_hit.
- FSM states RUN, HOLD2, HOLD1; state register updates on the rising edge.
- RUN:
  - If need2 or need1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 this cycle. Next state is HOLD1 if need2, else RUN (hazard re-evaluated next cycle).
  - Otherwise: pc_write=1, if_id_write=1, id_ex_bubble=0, if_id_flush=(id_is_jump or (id_is_branch and id_branch_taken)); stay RUN.
- HOLD1: stall outputs asserted unconditionally; all hazard inputs ignored; next state RUN.
- HOLD2 is reserved for future use and decodes as HOLD1. Illegal encodings return to RUN.
- Stall and flush are mutually exclusive; a stalled branch or jump never flushes in the same cycle.
- Latency: stall outputs in RUN are combinational, same cycle as detection. HOLD stalls are registered.
- Load feeding a branch gives exactly 2 stall cycles total. ALU result or MEM-stage load feeding a branch gives 1. Plain load-use gives 1.
- Reset (asynchronous):
  - While reset is high: state=RUN, stall_cnt=0, pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
  - Normal operation starts on the first edge after deassertion.
  - Reset asserted mid-HOLD aborts the stall immediately.
- stall_cnt increments on each clock edge where pc_write=0 and reset is low. It saturates at all-ones; no wrap-around.

Optional Feature:
- STALL_COUNTER_EN defined: stall_cnt counter implemented as above.
- STALL_COUNTER_EN not defined: no counter flops; stall_cnt tied to 0; all other behaviour identical.

Test Plan:
- lw $2 in EX (ex_memread=1, ex_dst=2); add uses rs=2 in ID -> exactly 1 cycle with pc_write=0, id_ex_bubble=1; next cycle (lw in MEM, not a branch) pc_write=1; stall_cnt=1.
- lw $3 in EX; beq rs=3, rt=4 in ID -> 2 consecutive stall cycles (RUN->HOLD1->RUN); id_branch_taken ignored during the stall; stall_cnt=2.
- add $5 in EX (ex_regwrite=1, ex_dst=5); beq rs=5 in ID; BRANCH_IN_ID=1 -> 1 stall. Same stimulus with BRANCH_IN_ID=0 -> 0 stalls.
- ex_dst=0 with ex_memread=1 and id_rs=0 -> no stall. beq taken with no hazard -> if_id_flush=1 for 1 cycle, pc_write=1. j -> if_id_flush=1.
- Assert reset while in HOLD1 -> outputs go to reset values without waiting for a clock edge; stall_cnt=0; after release, state RUN.
- Force 2^CNT_W+3 stall cycles with CNT_W=4 -> stall_cnt holds at 15. With STALL_COUNTER_EN undefined -> stall_cnt stays 0.
